// File: rtl/afu_stream_ctrl.sv
// Job sequencer for the complex-multiply stream datapath. It issues credit-throttled
// indexed reads, pops the output FIFO into indexed writes, and counts write completions.
module afu_stream_ctrl #(
  parameter int BUFF_DEPTH_BITS = 3,
  parameter int CREDITS         = 6,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          ctx_length,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_req_valid,
  input  logic                 rd_req_ready,
  output logic [CNT_WIDTH-1:0] rd_req_idx,
  input  logic                 out_fifo_empty,
  output logic                 out_fifo_re,
  output logic                 wr_req_valid,
  input  logic                 wr_req_ready,
  output logic [CNT_WIDTH-1:0] wr_req_idx,
  input  logic                 wr_rsp_valid
);

  if (CREDITS < 1 || CREDITS > (1 << BUFF_DEPTH_BITS)) begin : g_bad_credits
    $error("afu_stream_ctrl: CREDITS must be within 1..2**BUFF_DEPTH_BITS");
  end

  localparam logic [CNT_WIDTH-1:0] CRED = CNT_WIDTH'(CREDITS);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0] rsp_cnt_q, rsp_cnt_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 wr_vld_q, wr_vld_d;
  logic                 re_q;
  logic                 rd_acc, wr_acc, pop;

  always_comb begin
    busy      = (state_q == RUN) || (state_q == DRAIN);
    done      = (state_q == DONE);
    rd_acc    = rd_vld_q & rd_req_ready;
    wr_acc    = wr_vld_q & wr_req_ready;
    // Pop only into an empty write slot, or into one being drained this cycle.
    pop       = busy & ~out_fifo_empty & (pop_cnt_q < len_q) &
                ((~wr_vld_q & ~re_q) | wr_acc);

    state_d   = state_q;
    len_d     = len_q;
    rd_cnt_d  = (busy && rd_acc)       ? rd_cnt_q  + ONE : rd_cnt_q;
    pop_cnt_d = pop                    ? pop_cnt_q + ONE : pop_cnt_q;
    wr_cnt_d  = (busy && wr_acc)       ? wr_cnt_q  + ONE : wr_cnt_q;
    rsp_cnt_d = (busy && wr_rsp_valid) ? rsp_cnt_q + ONE : rsp_cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d     = CNT_WIDTH'(ctx_length);
          rd_cnt_d  = '0;
          pop_cnt_d = '0;
          wr_cnt_d  = '0;
          rsp_cnt_d = '0;
          state_d   = (ctx_length == 32'd0) ? DONE : RUN;
        end
      end
      RUN:     if (rd_cnt_q == len_q)  state_d = DRAIN;
      DRAIN:   if (rsp_cnt_q == len_q) state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Evaluated on next-state counters so a credit consumed this edge is never re-offered.
    rd_vld_d = (state_d == RUN) && (rd_cnt_d < len_d) && ((rd_cnt_d - pop_cnt_d) < CRED);
    wr_vld_d = pop | (wr_vld_q & ~wr_req_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      pop_cnt_q <= '0;
      wr_cnt_q  <= '0;
      rsp_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      re_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      pop_cnt_q <= pop_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      rd_vld_q  <= rd_vld_d;
      wr_vld_q  <= wr_vld_d;
      re_q      <= pop;
    end
  end

  assign rd_req_valid = rd_vld_q;
  assign rd_req_idx   = rd_cnt_q;
  assign out_fifo_re  = pop;
  assign wr_req_valid = wr_vld_q;
  assign wr_req_idx   = wr_cnt_q;

endmodule

// File: tb/tb_afu_stream_ctrl.sv
// Bench for afu_stream_ctrl: a host/datapath environment model plus directed jobs
// checked against index sequences, counts and handshake rules.
module tb_afu_stream_ctrl;
  localparam int CREDITS = 6;

  logic        clk = 0, reset = 0, start = 0;
  logic [31:0] ctx_length = 0;
  logic        busy, done, rd_req_valid, rd_req_ready = 0;
  logic [31:0] rd_req_idx, wr_req_idx;
  logic        out_fifo_empty = 1, out_fifo_re, wr_req_valid, wr_req_ready = 0, wr_rsp_valid = 0;

  afu_stream_ctrl #(.BUFF_DEPTH_BITS(3), .CREDITS(CREDITS), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ctx_length(ctx_length),
    .busy(busy), .done(done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_idx(rd_req_idx),
    .out_fifo_empty(out_fifo_empty), .out_fifo_re(out_fifo_re),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_idx(wr_req_idx),
    .wr_rsp_valid(wr_rsp_valid)
  );

  always #5 clk = ~clk;

  // Environment state: written only by the env process.
  int fifo_cnt = 0, rd_acc = 0, pops = 0, act = 0, cyc = 0;
  int viol_fifo = 0, viol_rd = 0, viol_wr = 0;
  int rd_log[$], wr_log[$], pop_cyc[$], wr_cyc[$], rsp_due[$];
  logic        prev_rd_stall = 0, prev_wr_stall = 0;
  logic [31:0] prev_rd_idx = 0, prev_wr_idx = 0;
  // Environment knobs: written only by the main initial block.
  int pop_limit = 1 << 30, rd_limit = 1 << 30;
  bit rand_rd = 0, rand_wr = 0;

  // Inputs change 1 time unit after posedge; handshakes are sampled at negedge
  // and take effect at the following posedge. Datapath lines land in the output
  // FIFO as soon as their read is accepted; outstanding lines == fifo_cnt.
  always begin
    @(posedge clk); #1;
    rd_req_ready   = (rd_acc < rd_limit) && (!rand_rd || ($urandom_range(0, 1) == 1));
    wr_req_ready   = !rand_wr || ($urandom_range(0, 1) == 1);
    out_fifo_empty = (fifo_cnt == 0) || (pops >= pop_limit);
    wr_rsp_valid   = (rsp_due.size() > 0) && (rsp_due[0] <= cyc);
    if (wr_rsp_valid) void'(rsp_due.pop_front());
    @(negedge clk);
    cyc++;
    if (reset) begin
      fifo_cnt = 0; rsp_due.delete(); prev_rd_stall = 0; prev_wr_stall = 0;
    end else begin
      if (prev_rd_stall && rd_req_valid && rd_req_idx !== prev_rd_idx) viol_rd++;
      if (prev_wr_stall && (!wr_req_valid || wr_req_idx !== prev_wr_idx)) viol_wr++;
      if (wr_req_valid && !wr_req_ready && out_fifo_re) viol_wr++;
      if (rd_req_valid || out_fifo_re || wr_req_valid) act++;
      if (rd_req_valid && rd_req_ready) begin
        rd_log.push_back(int'(rd_req_idx)); rd_acc++; fifo_cnt++;
      end
      if (out_fifo_re) begin
        fifo_cnt--; pops++; pop_cyc.push_back(cyc);
      end
      if (wr_req_valid && wr_req_ready) begin
        wr_log.push_back(int'(wr_req_idx)); wr_cyc.push_back(cyc); rsp_due.push_back(cyc + 3);
      end
      if (fifo_cnt > CREDITS || fifo_cnt < 0) viol_fifo++;
      prev_rd_stall = rd_req_valid && !rd_req_ready;
      prev_rd_idx   = rd_req_idx;
      prev_wr_stall = wr_req_valid && !wr_req_ready;
      prev_wr_idx   = wr_req_idx;
    end
  end

  int checks = 0, errs = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected log tail: exactly n entries 0..n-1 after position base.
  task automatic check_seq(input string tag, input int q[$], input int base, input int n);
    int bad = 0;
    check({tag, "_count"}, q.size() - base, n);
    for (int i = 0; i < n && base + i < q.size(); i++) if (q[base + i] != i) bad++;
    check({tag, "_order"}, bad, 0);
  endtask

  task automatic pulse_start(input int len);
    @(posedge clk); #1; start = 1; ctx_length = len;
    @(posedge clk); #1; start = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (!done && n < budget) begin @(negedge clk); n++; end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int rb, wb, a0, n;

  initial begin
    reset = 1;
    idle(2);
    check("rst_busy", busy, 0); check("rst_done", done, 0);
    check("rst_rdv", rd_req_valid, 0); check("rst_re", out_fifo_re, 0);
    check("rst_wrv", wr_req_valid, 0);
    check("rst_rdidx", rd_req_idx, 0); check("rst_wridx", wr_req_idx, 0);
    #1 reset = 0;

    // Zero-length job: done the cycle after start, no traffic at all.
    a0 = act;
    pulse_start(0);
    check("len0_done", done, 1);
    idle(10);
    check("len0_done_hold", done, 1);
    check("len0_activity", act - a0, 0);

    // Single line.
    rb = rd_log.size(); wb = wr_log.size();
    pulse_start(1);
    check("len1_busy", busy, 1);
    check("len1_done_drop", done, 0);
    wait_done("len1", 100);
    check_seq("len1_rd", rd_log, rb, 1);
    check_seq("len1_wr", wr_log, wb, 1);

    // Credit limit with no data returning, then two pops release two credits.
    rb = rd_log.size(); wb = wr_log.size();
    pop_limit = pops;
    pulse_start(20);
    idle(20);
    check_seq("cred_rd6", rd_log, rb, CREDITS);
    check("cred_rdv_low", rd_req_valid, 0);
    pop_limit = pops + 2;
    idle(20);
    check_seq("cred_rd8", rd_log, rb, CREDITS + 2);
    pop_limit = 1 << 30;
    wait_done("cred", 400);
    check_seq("cred_wr", wr_log, wb, 20);

    // Full-rate streaming: FIFO pre-filled to the credit limit, then released.
    rb = rd_log.size(); wb = wr_log.size();
    pop_limit = pops;
    pulse_start(16);
    n = 0;
    while (fifo_cnt < CREDITS && n < 50) begin @(negedge clk); n++; end
    check("rate_prefill", fifo_cnt, CREDITS);
    a0 = pop_cyc.size();
    pop_limit = 1 << 30;
    wait_done("rate", 300);
    check_seq("rate_wr", wr_log, wb, 16);
    check_seq("rate_rd", rd_log, rb, 16);
    check("rate_pop_n", pop_cyc.size() - a0, 16);
    if (pop_cyc.size() - a0 == 16) check("rate_pop_span", pop_cyc[a0 + 15] - pop_cyc[a0], 15);
    if (wr_cyc.size() - wb == 16) check("rate_wr_span", wr_cyc[wb + 15] - wr_cyc[wb], 15);

    // Random ready on both sides.
    rb = rd_log.size(); wb = wr_log.size();
    rand_rd = 1; rand_wr = 1;
    pulse_start(10);
    wait_done("rand", 1000);
    rand_rd = 0; rand_wr = 0;
    check_seq("rand_wr", wr_log, wb, 10);
    check_seq("rand_rd", rd_log, rb, 10);

    // Start while running is ignored.
    rb = rd_log.size(); wb = wr_log.size();
    pulse_start(5);
    idle(1);
    pulse_start(9);
    wait_done("ign", 300);
    idle(10);
    check("ign_no_restart", busy, 0);
    check_seq("ign_wr", wr_log, wb, 5);
    check_seq("ign_rd", rd_log, rb, 5);

    // Asynchronous reset after three reads of a ten-line job.
    rb = rd_log.size();
    rd_limit = rd_acc + 3;
    pulse_start(10);
    n = 0;
    while (rd_acc < rd_limit && n < 100) begin @(negedge clk); n++; end
    check("rst_mid_reads", rd_log.size() - rb, 3);
    #2 reset = 1;
    #1;
    check("mid_busy", busy, 0); check("mid_done", done, 0);
    check("mid_rdv", rd_req_valid, 0); check("mid_re", out_fifo_re, 0);
    check("mid_wrv", wr_req_valid, 0);
    check("mid_rdidx", rd_req_idx, 0); check("mid_wridx", wr_req_idx, 0);
    rd_limit = 1 << 30;
    idle(2);
    #1 reset = 0;
    rb = rd_log.size();
    pulse_start(2);
    wait_done("post_rst", 200);
    check_seq("post_rst_rd", rd_log, rb, 2);

    check("viol_fifo", viol_fifo, 0);
    check("viol_rd_stable", viol_rd, 0);
    check("viol_wr_stable", viol_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
